// File: rtl/div_seq.sv
// Sequential restoring divider: q = g_input / e_input, r = g_input % e_input over CC cycles,
// retiring N/CC quotient bits per cycle. Define DIV_SIGNED_EN for two's-complement operands.
module div_seq #(
  parameter int N  = 128,
  parameter int CC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] g_input,
  input  logic [N-1:0] e_input,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         dz,
  output logic [1:0]   state_dbg
);

  // Handshake: start is sampled only in IDLE or DONE; done pulses for one cycle and
  // q/r/dz are valid from that cycle, held until the next done. start in RUN is ignored.

  localparam int SPC = N / CC;
  localparam int CW  = (CC > 1) ? $clog2(CC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CC - 1);

  if (N % CC != 0) begin : g_cc_check
    $error("div_seq: N must be a multiple of CC");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  dvd;
  logic [N-1:0]  dvs;
  logic [N-1:0]  quo;
  logic [N:0]    rem;
  logic [CW-1:0] count;
  logic          dz_l;

  logic [N-1:0]  g_mag;
  logic [N-1:0]  e_mag;
  logic [N-1:0]  dvd_n;
  logic [N-1:0]  quo_n;
  logic [N:0]    rem_n;
  logic [N-1:0]  q_fin;
  logic [N-1:0]  r_fin;

  assign state_dbg = state;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // The core always divides magnitudes; signs are restored when results are loaded.
  always_comb begin
    g_mag = g_input[N-1] ? -g_input : g_input;
    e_mag = e_input[N-1] ? -e_input : e_input;
  end

  always_comb begin
    q_fin = neg_q ? -quo_n : quo_n;
    if (dz_l) q_fin = '1;
    r_fin = neg_r ? -rem_n[N-1:0] : rem_n[N-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if ((state == S_IDLE || state == S_DONE) && start) begin
      neg_q <= g_input[N-1] ^ e_input[N-1];
      neg_r <= g_input[N-1];
    end
  end
`else
  always_comb begin
    g_mag = g_input;
    e_mag = e_input;
    q_fin = quo_n;
    r_fin = rem_n[N-1:0];
  end
`endif

  // SPC shift-subtract steps per RUN edge, MSB of the dividend first.
  always_comb begin
    rem_n = rem;
    dvd_n = dvd;
    quo_n = quo;
    for (int i = 0; i < SPC; i++) begin
      rem_n = {rem_n[N-1:0], dvd_n[N-1]};
      dvd_n = {dvd_n[N-2:0], 1'b0};
      if (rem_n >= {1'b0, dvs}) begin
        rem_n = rem_n - {1'b0, dvs};
        quo_n = {quo_n[N-2:0], 1'b1};
      end else begin
        quo_n = {quo_n[N-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
      dvd   <= '0;
      dvs   <= '0;
      quo   <= '0;
      rem   <= '0;
      count <= '0;
      dz_l  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            dvd   <= g_mag;
            dvs   <= e_mag;
            quo   <= '0;
            rem   <= '0;
            count <= '0;
            dz_l  <= (e_input == '0);
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          dvd   <= dvd_n;
          quo   <= quo_n;
          rem   <= rem_n;
          count <= count + 1'b1;
          if (count == LAST) begin
            q     <= q_fin;
            r     <= r_fin;
            dz    <= dz_l;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq at N=8 with three instances: CC=4 (scenarios), CC=1 and CC=8 (sweeps).
// Also builds with DIV_SIGNED_EN defined, switching the reference model to signed.
module tb_div_seq;

  logic       clk;
  logic       rst;
  logic       start_a [3];
  logic [7:0] g_a     [3];
  logic [7:0] e_a     [3];
  logic       busy_a  [3];
  logic       done_a  [3];
  logic [7:0] q_a     [3];
  logic [7:0] r_a     [3];
  logic       dz_a    [3];
  logic [1:0] st_a    [3];

  logic [16:0] exp_q[$];
  int checks;
  int errors;

  div_seq #(.N(8), .CC(4)) u_cc4 (
    .clk(clk), .rst(rst), .start(start_a[0]), .g_input(g_a[0]), .e_input(e_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .q(q_a[0]), .r(r_a[0]), .dz(dz_a[0]),
    .state_dbg(st_a[0])
  );
  div_seq #(.N(8), .CC(1)) u_cc1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .g_input(g_a[1]), .e_input(e_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .q(q_a[1]), .r(r_a[1]), .dz(dz_a[1]),
    .state_dbg(st_a[1])
  );
  div_seq #(.N(8), .CC(8)) u_cc8 (
    .clk(clk), .rst(rst), .start(start_a[2]), .g_input(g_a[2]), .e_input(e_a[2]),
    .busy(busy_a[2]), .done(done_a[2]), .q(q_a[2]), .r(r_a[2]), .dz(dz_a[2]),
    .state_dbg(st_a[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cc_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 8;
  endfunction

  // Golden {q, r, dz} from the language's own / and % operators.
  function automatic logic [16:0] model(input logic [7:0] g, input logic [7:0] e);
    int gi;
    int ei;
    int qi;
    int ri;
    if (e == 8'd0) return {8'hFF, g, 1'b1};
`ifdef DIV_SIGNED_EN
    gi = int'($signed(g));
    ei = int'($signed(e));
`else
    gi = int'(g);
    ei = int'(e);
`endif
    qi = gi / ei;
    ri = gi % ei;
    return {qi[7:0], ri[7:0], 1'b0};
  endfunction

  task automatic do_op(input int k, input logic [7:0] g, input logic [7:0] e,
                       input logic [16:0] exp_v);
    int n;
    int busy_n;
    logic got;
    logic [16:0] act;
    logic [16:0] want;
    @(negedge clk);
    start_a[k] = 1'b1;
    g_a[k] = g;
    e_a[k] = e;
    exp_q.push_back(exp_v);
    @(negedge clk);
    start_a[k] = 1'b0;
    n = 0;
    busy_n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      n++;
      if (done_a[k]) got = 1'b1;
      else begin
        if (busy_a[k]) busy_n++;
        @(negedge clk);
      end
    end
    want = exp_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL op_timeout k=%0d g=%0d e=%0d waited %0d cycles", k, g, e, n);
      return;
    end
    act = {q_a[k], r_a[k], dz_a[k]};
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL result k=%0d g=%h e=%h got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
               k, g, e, act[16:9], act[8:1], act[0], want[16:9], want[8:1], want[0]);
    end
    checks++;
    if (n !== cc_of(k) + 1) begin
      errors++;
      $display("FAIL latency k=%0d got %0d want %0d", k, n, cc_of(k) + 1);
    end
    checks++;
    if (busy_n !== cc_of(k) || busy_a[k] !== 1'b0) begin
      errors++;
      $display("FAIL busy_cycles k=%0d got %0d busy_at_done=%b want %0d and 0", k, busy_n,
               busy_a[k], cc_of(k));
    end
    @(negedge clk);
    checks++;
    if (done_a[k] !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse k=%0d done still %b want 0", k, done_a[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_a[k] = 1'b0;
      g_a[k] = 8'd0;
      e_a[k] = 8'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({busy_a[k], done_a[k], q_a[k], r_a[k], dz_a[k], st_a[k]} !== 21'd0) begin
        errors++;
        $display("FAIL reset_state k=%0d busy=%b done=%b q=%h r=%h dz=%b st=%0d want all 0",
                 k, busy_a[k], done_a[k], q_a[k], r_a[k], dz_a[k], st_a[k]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_op(0, 8'd100, 8'd7, {8'd14, 8'd2, 1'b0});
    do_op(0, 8'd5, 8'd0, {8'hFF, 8'd5, 1'b1});
    do_op(0, 8'd0, 8'd0, {8'hFF, 8'd0, 1'b1});
    do_op(0, 8'd13, 8'd1, model(8'd13, 8'd1));
    do_op(0, 8'd3, 8'd250, model(8'd3, 8'd250));
  endtask

  task automatic test_back_to_back();
    int n;
    logic got;
    logic [16:0] want;
    @(negedge clk);
    start_a[0] = 1'b1;
    g_a[0] = 8'd200;
    e_a[0] = 8'd9;
    exp_q.push_back(model(8'd200, 8'd9));
    @(negedge clk);
    g_a[0] = 8'd255;
    e_a[0] = 8'd255;
    exp_q.push_back(model(8'd255, 8'd255));
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      n++;
      if (done_a[0]) got = 1'b1;
      else @(negedge clk);
    end
    want = exp_q.pop_front();
    checks++;
    if (!got || {q_a[0], r_a[0], dz_a[0]} !== want) begin
      errors++;
      $display("FAIL b2b_first got q=%h r=%h done_seen=%b want q=%h r=%h", q_a[0], r_a[0],
               got, want[16:9], want[8:1]);
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) start_a[0] = 1'b0;
      if (done_a[0]) got = 1'b1;
    end
    want = exp_q.pop_front();
    checks++;
    if (!got || {q_a[0], r_a[0], dz_a[0]} !== want) begin
      errors++;
      $display("FAIL b2b_second got q=%h r=%h done_seen=%b want q=%h r=%h", q_a[0], r_a[0],
               got, want[16:9], want[8:1]);
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL b2b_spacing got %0d cycles want 5", n);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_in_run();
    int n;
    logic got;
    logic [16:0] want;
    @(negedge clk);
    start_a[0] = 1'b1;
    g_a[0] = 8'd100;
    e_a[0] = 8'd7;
    exp_q.push_back({8'd14, 8'd2, 1'b0});
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      start_a[0] = (n == 2);
      if (n == 2) begin
        g_a[0] = 8'd3;
        e_a[0] = 8'd3;
      end
      if (done_a[0]) got = 1'b1;
    end
    start_a[0] = 1'b0;
    want = exp_q.pop_front();
    checks++;
    if (!got || {q_a[0], r_a[0], dz_a[0]} !== want || n !== 5) begin
      errors++;
      $display("FAIL ignore_in_run got q=%h r=%h at cycle %0d want q=%h r=%h at 5",
               q_a[0], r_a[0], n, want[16:9], want[8:1]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    start_a[0] = 1'b1;
    g_a[0] = 8'd50;
    e_a[0] = 8'd3;
    @(negedge clk);
    start_a[0] = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({busy_a[0], done_a[0], q_a[0], r_a[0], dz_a[0], st_a[0]} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid_run busy=%b done=%b q=%h r=%h dz=%b st=%0d want all 0",
               busy_a[0], done_a[0], q_a[0], r_a[0], dz_a[0], st_a[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_a[0]) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abandoned_done got %0d done pulses want 0", seen);
    end
    do_op(0, 8'd100, 8'd7, {8'd14, 8'd2, 1'b0});
    do_op(0, 8'd77, 8'd5, model(8'd77, 8'd5));
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    do_op(0, 8'd156, 8'd7, {8'hF2, 8'hFE, 1'b0});
    do_op(0, 8'd100, 8'hF9, {8'hF2, 8'h02, 1'b0});
    do_op(0, 8'h80, 8'hFF, {8'h80, 8'h00, 1'b0});
    do_op(0, 8'hFB, 8'd0, {8'hFF, 8'hFB, 1'b1});
  endtask
`endif

  task automatic test_sweep(input int k);
    logic [7:0] g;
    logic [7:0] e;
    do_op(k, 8'd255, 8'd1, model(8'd255, 8'd1));
    do_op(k, 8'd128, 8'd255, model(8'd128, 8'd255));
    do_op(k, 8'd0, 8'd9, model(8'd0, 8'd9));
    do_op(k, 8'd127, 8'd0, model(8'd127, 8'd0));
    for (int i = 0; i < 1000; i++) begin
      g = 8'($urandom_range(0, 255));
      e = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      do_op(k, g, e, model(g, e));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_in_run();
    test_reset_mid_run();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    test_sweep(1);
    test_sweep(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
